// File: rtl/flit_injector.sv
// Requester-side flit source for one router input port: turns a packet
// descriptor plus a payload word stream into header/body/tail flits for the arbiter.
module flit_injector #(
    parameter int DATA_W = 32,
    parameter int SLACK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [11:0]       pkt_len,
    input  logic [DATA_W-1:0] pkt_hdr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_xfer,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_TAIL,
        S_WAIT
    } state_t;

    localparam logic [2:0] ID_NONE = 3'b000;
    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              pkt_ready_q, pkt_ready_d;
    logic [2:0]        id_q, id_d;
    logic [11:0]       len_q, len_d;
    logic [11:0]       rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [11:0]       eff;
    logic              load;

    function automatic logic [11:0] sat_budget(input logic [11:0] flits);
        logic [31:0] sum;
        sum = {20'd0, flits} + 32'(SLACK);
        return (sum > 32'd4095) ? 12'd4095 : sum[11:0];
    endfunction

    assign eff = (pkt_len < 12'd2) ? 12'd2 : pkt_len;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        busy_d    = busy_q;
        id_d      = id_q;
        len_d     = len_q;
        rem_d     = rem_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        flit_xfer = 1'b0;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid && pkt_ready_q) begin
                    len_d   = sat_budget(eff);
                    rem_d   = eff - 12'd1;
                    id_d    = ID_HEAD;
                    data_d  = pkt_hdr;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_HEAD;
                end
            end
            S_HEAD, S_BODY: begin
                flit_xfer = grant;
                if (grant) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        // Current flit is gone but the next word is late: present nothing.
                        id_d    = ID_NONE;
                        state_d = S_WAIT;
                    end
                end
            end
            S_TAIL: begin
                flit_xfer = grant;
                if (grant) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    id_d    = ID_NONE;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // rem_q counts payload words still to load, including this one.
        if (load) begin
            in_ready = 1'b1;
            data_d   = in_data;
            rem_d    = rem_q - 12'd1;
            if (rem_q == 12'd1) begin
                id_d    = ID_TAIL;
                state_d = S_TAIL;
            end else begin
                id_d    = ID_BODY;
                state_d = S_BODY;
            end
        end
    end

    assign pkt_ready_d = (state_d == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            pkt_ready_q <= 1'b0;
            id_q        <= ID_NONE;
            len_q       <= 12'd0;
            rem_q       <= 12'd0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            pkt_ready_q <= pkt_ready_d;
            id_q        <= id_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
        end
    end

    assign req       = req_q;
    assign busy      = busy_q;
    assign pkt_ready = pkt_ready_q;
    assign flit_id   = id_q;
    assign length    = len_q;
    assign flit_data = data_q;

endmodule

// File: tb/tb_flit_injector.sv
// Scoreboard bench for flit_injector: expected flits are queued when a
// descriptor is accepted and compared as the injector transfers them.
module tb_flit_injector;

    localparam int DATA_W = 32;
    localparam int SLACK  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pkt_valid = 1'b0;
    logic              pkt_ready;
    logic [11:0]       pkt_len = '0;
    logic [DATA_W-1:0] pkt_hdr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              grant = 1'b0;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic [DATA_W-1:0] flit_data;
    logic              flit_xfer;
    logic              busy;

    always #5 clk = ~clk;

    flit_injector #(.DATA_W(DATA_W), .SLACK(SLACK)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len), .pkt_hdr(pkt_hdr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .grant(grant), .req(req), .flit_id(flit_id), .length(length),
        .flit_data(flit_data), .flit_xfer(flit_xfer), .busy(busy)
    );

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
    } flit_t;

    typedef struct packed {
        logic [11:0] len;
        logic [31:0] hdr;
        logic [31:0] base;
    } desc_t;

    flit_t       expq[$];
    desc_t       descq[$];
    logic [31:0] payq[$];

    int n_checks = 0;
    int n_errors = 0;

    int          cur_eff = 0, xfers = 0, busy_cyc = 0, words = 0, gap = 0;
    int          wait_cycles = 0, grant_low_busy = 0;
    int          grant_stall_at = 0, grant_stall = 0, inv_stall_at = 0, inv_stall = 0;
    bit          rand_mode = 0, stall_free = 1, tail_seen = 0, gap_track = 0, prev_valid = 0;
    logic [11:0] exp_len = '0;
    logic [2:0]  prev_id = '0;
    logic [31:0] prev_data = '0;
    logic        prev_grant = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic accept_desc();
        desc_t d;
        int    e;
        d = descq.pop_front();
        e = (d.len < 12'd2) ? 2 : int'(d.len);
        exp_len = (e + SLACK > 4095) ? 12'd4095 : 12'(e + SLACK);
        expq.push_back({3'b001, d.hdr});
        for (int i = 0; i < e - 1; i++) begin
            expq.push_back({(i == e - 2) ? 3'b100 : 3'b010, d.base + 32'(i)});
            payq.push_back(d.base + 32'(i));
        end
        cur_eff  = e;
        xfers    = 0;
        busy_cyc = 0;
        words    = 0;
    endtask

    // Sampled at the falling edge, when inputs and outputs of the cycle are stable.
    task automatic observe();
        flit_t f;
        logic  exp_ir;
        if (tail_seen) begin
            check("req_after_tail", 64'(req), 64'(0));
            check("busy_after_tail", 64'(busy), 64'(0));
            check("ready_after_tail", 64'(pkt_ready), 64'(1));
            tail_seen = 0;
        end
        if (gap_track) begin
            if (req) begin
                check("idle_gap", 64'(gap), 64'(1));
                gap_track = 0;
            end else begin
                gap++;
            end
        end
        check("xfer", 64'(flit_xfer), 64'(grant && flit_id != 3'b000));
        if (flit_id == 3'b001 || flit_id == 3'b010) exp_ir = grant && in_valid;
        else if (flit_id == 3'b000 && busy)        exp_ir = in_valid;
        else                                        exp_ir = 1'b0;
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        if (busy && flit_id == 3'b000) begin
            wait_cycles++;
            check("wait_req", 64'(req), 64'(1));
        end
        if (busy && !grant) grant_low_busy++;
        if (prev_valid && !prev_grant && prev_id != 3'b000) begin
            check("hold_id", 64'(flit_id), 64'(prev_id));
            check("hold_data", 64'(flit_data), 64'(prev_data));
            check("hold_req", 64'(req), 64'(1));
        end
        if (busy) busy_cyc++;
        if (pkt_valid && pkt_ready) accept_desc();
        if (in_valid && in_ready) begin
            if (payq.size() > 0) void'(payq.pop_front());
            words++;
            if (inv_stall_at != 0 && words == inv_stall_at) inv_stall = 3;
        end
        if (flit_xfer) begin
            xfers++;
            if (expq.size() == 0) begin
                check("unexpected_flit", 64'(flit_id), 64'(0));
            end else begin
                f = expq.pop_front();
                check("flit_id", 64'(flit_id), 64'(f.id));
                check("flit_data", 64'(flit_data), 64'(f.data));
                if (f.id == 3'b001) check("length", 64'(length), 64'(exp_len));
                if (f.id == 3'b100) begin
                    check("nflits", 64'(xfers), 64'(cur_eff));
                    if (stall_free) check("pkt_cycles", 64'(busy_cyc), 64'(cur_eff));
                    tail_seen = 1;
                    gap_track = (descq.size() > 0);
                    gap = 0;
                end
            end
            if (grant_stall_at != 0 && xfers == grant_stall_at) grant_stall = 5;
        end
        prev_valid = 1;
        prev_grant = grant;
        prev_id    = flit_id;
        prev_data  = flit_data;
    endtask

    task automatic drive();
        if (grant_stall > 0) begin
            grant = 1'b0;
            grant_stall--;
        end else if (rand_mode) begin
            grant = ($urandom_range(0, 3) != 0);
        end else begin
            grant = 1'b1;
        end
        pkt_valid = (descq.size() > 0);
        if (descq.size() > 0) begin
            pkt_len = descq[0].len;
            pkt_hdr = descq[0].hdr;
        end
        if (inv_stall > 0) begin
            in_valid = 1'b0;
            inv_stall--;
        end else if (rand_mode) begin
            in_valid = (payq.size() > 0) && ($urandom_range(0, 2) != 0);
        end else begin
            in_valid = (payq.size() > 0);
        end
        in_data = (payq.size() > 0) ? payq[0] : 32'd0;
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        drive();
        do begin
            cycle();
            n++;
        end while (n < budget && (descq.size() > 0 || expq.size() > 0 || tail_seen || gap_track));
        check("drained", 64'(descq.size() == 0 && expq.size() == 0), 64'(1));
    endtask

    task automatic push_desc(input int len, input logic [31:0] hdr, input logic [31:0] base);
        descq.push_back({12'(len), hdr, base});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(req), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_ready"}, 64'(pkt_ready), 64'(0));
        check({tag, "_id"}, 64'(flit_id), 64'(0));
        check({tag, "_len"}, 64'(length), 64'(0));
        check({tag, "_data"}, 64'(flit_data), 64'(0));
        check({tag, "_xfer"}, 64'(flit_xfer), 64'(0));
        check({tag, "_inrdy"}, 64'(in_ready), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic packet with always-ready payload and continuous grant.
        push_desc(4, 32'hA5, 32'd1);
        run_idle(100);

        // Degenerate lengths, back to back.
        push_desc(0, 32'h100, 32'h10);
        push_desc(1, 32'h101, 32'h20);
        run_idle(100);

        // Budget saturation on a long packet.
        push_desc(4094, 32'hBEEF, 32'h1000);
        run_idle(5000);

        // Grant withdrawn for 5 cycles after the second body flit.
        stall_free = 0;
        grant_stall_at = 3;
        grant_low_busy = 0;
        push_desc(6, 32'h44, 32'h400);
        run_idle(100);
        check("grant_stall_cycles", 64'(grant_low_busy), 64'(5));
        grant_stall_at = 0;

        // Payload underrun for 3 cycles mid-packet.
        inv_stall_at = 2;
        wait_cycles = 0;
        push_desc(6, 32'h55, 32'h500);
        run_idle(100);
        check("wait_cycles", 64'(wait_cycles), 64'(3));
        inv_stall_at = 0;

        // Asynchronous reset while a body flit is presented.
        push_desc(8, 32'h66, 32'h600);
        xfers = 0;
        n = 0;
        drive();
        while (xfers < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("reached_body", 64'(xfers), 64'(2));
        check("body_presented", 64'(flit_id), 64'(3'b010));
        #3 rst = 1'b0;
        #1 check_all_zero("async_rst");
        expq.delete();
        payq.delete();
        descq.delete();
        tail_seen = 0; gap_track = 0; prev_valid = 0; xfers = 0;
        grant_stall = 0; inv_stall = 0;
        drive();
        @(posedge clk);
        #1 check_all_zero("rst_held");
        @(negedge clk);
        rst = 1'b1;
        stall_free = 1;
        push_desc(3, 32'h77, 32'h700);
        run_idle(100);

        // Random grant and payload availability over several packets.
        rand_mode = 1;
        stall_free = 0;
        for (int p = 0; p < 6; p++) begin
            push_desc($urandom_range(0, 9), $urandom, 32'h8000 + 32'(p) * 32'h100);
        end
        run_idle(1000);
        rand_mode = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
- Requester-side source for one router input port; the other end of the per-port arbiter handshake.
- Accepts a packet descriptor plus a stream of payload words and serialises them into header, body and tail flits.
- Drives `req`, `flit_id`, `length` and `flit_data` toward the arbiter and advances one flit per cycle while `grant` is high.
- One instance sits in front of each of the L/N/E/W/S arbiter inputs.

Parameters:
- DATA_W, 32, flit payload width.
- SLACK, 4, extra cycles added to the packet flit count to form the timeout budget on `length`.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- pkt_valid  input  1  descriptor available.
- pkt_ready  output  1  descriptor accepted when pkt_valid && pkt_ready.
- pkt_len  input  12  total flits incl. header.
- pkt_hdr  input  DATA_W  header flit payload.
- in_valid  input  1  payload word available.
- in_ready  output  1  payload word consumed when in_valid && in_ready.
- in_data  input  DATA_W  payload word.
- grant  input  1  arbiter has this port selected in the current cycle.
- req  output  1  request to arbiter.
- flit_id  output  3  000 idle, 001 header, 010 body, 100 tail.
- length  output  12  timeout budget; valid while flit_id == 001.
- flit_data  output  DATA_W  current flit payload.
- flit_xfer  output  1  pulse; current flit accepted this cycle.
- busy  output  1  packet in progress.

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE; req, pkt_ready, in_ready, flit_xfer, busy = 0.
  - flit_id = 000; length = 0; flit_data = 0; remaining counter = 0.
- All outputs are registered except in_ready and flit_xfer, which are combinational from state, grant and in_valid.
- Effective length: eff = (pkt_len < 2) ? 2 : pkt_len.
  - eff flits are emitted: 1 header, eff − 2 body, 1 tail.
  - eff − 1 payload words are consumed.
- Timeout budget: length = min(eff + SLACK, 4095), saturating at 12 bits.
- State machine:
  - IDLE:
    - pkt_ready = 1.
    - On descriptor accept: latch the header and budget; remaining = eff − 1; flit_id = 001; flit_data = pkt_hdr; req = 1; busy = 1; go to HEAD.
  - HEAD:
    - flit_xfer = grant.
    - On grant: load the next flit from in_data if in_valid, otherwise go to WAIT.
    - flit_id becomes 010 if remaining > 1, or 100 if remaining == 1.
    - Go to BODY or TAIL accordingly.
  - BODY:
    - flit_xfer = grant.
    - On grant && in_valid: in_ready = 1; load next word; decrement remaining.
    - Switch to tail (100) when remaining reaches 1.
  - TAIL:
    - flit_xfer = grant.
    - On grant: req = 0; flit_id = 000; busy = 0; go to IDLE.
    - pkt_ready returns the cycle after.
  - WAIT (payload underrun):
    - req stays 1; flit_id = 000.
    - On in_valid: load the word and return to BODY or TAIL.
    - in_ready = 1 in WAIT only when in_valid.
- in_ready is asserted only in the cycle a word is loaded into flit_data.
- Grant dropped mid-packet (arbiter timeout or preemption):
  - flit_data and flit_id are held; req stays 1; remaining is unchanged.
  - Resume exactly where left off when grant returns.
- The header is re-sent only if it was never accepted; flit_id == 001 is never re-presented after a header transfer. This keeps the arbiter's budget latch unique per packet.
- grant while in IDLE is ignored: flit_xfer = 0.
- A new descriptor is not accepted before the tail transfer completes. Back-to-back packets have exactly 1 idle cycle with req = 0.
- Reset asserted mid-packet clears everything immediately; the partial packet is discarded with no tail.

Test Plan:
1. Reset, then pkt_len = 4, pkt_hdr = 0xA5, payload words 1, 2, 3 always valid, grant held 1.
   - Flits 001/0xA5, 010/1, 010/2, 100/3 on consecutive cycles.
   - length = 8 during the header; req drops the cycle after the tail transfer.
2. pkt_len = 0 and pkt_len = 1.
   - Both emit exactly header + tail; length = 6; one payload word consumed.
3. pkt_len = 4094, SLACK = 4.
   - length = 4095 (saturated); flit count = 4094.
4. grant low for 5 cycles after the second body flit.
   - req stays 1; flit_data and flit_id are frozen; no in_ready.
   - Sequence resumes unchanged when grant returns.
5. in_valid low for 3 cycles mid-packet.
   - WAIT state with flit_id = 000 and req = 1; no flit_xfer.
   - Next word delivered correctly once in_valid returns.
6. rst pulsed low during a body flit.
   - All outputs zero asynchronously; next packet starts cleanly from IDLE with a fresh header.
